qdec_ctx_arb: RTL and testbench

Arbiter and hazard scoreboard for the 1024x8 CABAC context memory, with each word holding {ctxState[6:0], mps}. It shares the single-port memory between the context-init writer, the syntax-FSM read path and the arithmetic-decoder state-update path. It blocks any read of a context whose update is still outstanding, so back-to-back bins on the same context never see a stale state. It sits between the syntax sub-FSMs / ctx init and the context RAM.

---
 rtl/qdec_ctx_arb.sv | 208 ++++++++++++++++++++
 tb/tb_qdec_ctx_arb.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qdec_ctx_arb.sv
// CABAC context-memory arbiter with lock scoreboard (init > upd > rd).
// Define QDEC_CTX_BYPASS_EN to forward upd_data straight to a read stalled on that context.
`timescale 1ns/1ps
module qdec_ctx_arb #(
    parameter int unsigned LOCK_DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       init_en,
    input  logic [9:0] init_addr,
    input  logic [7:0] init_wdata,
    input  logic       init_we,
    input  logic [9:0] rd_addr,
    input  logic       rd_lock,
    input  logic       rd_vld,
    output logic       rd_rdy,
    output logic [7:0] rd_data,
    output logic       rd_data_vld,
    input  logic [9:0] upd_addr,
    input  logic [7:0] upd_data,
    input  logic       upd_vld,
    output logic       upd_rdy,
    output logic [9:0] mem_addr,
    output logic [7:0] mem_wdata,
    output logic       mem_we,
    output logic       mem_re,
    input  logic [7:0] mem_rdata,
    output logic       err
);

    logic [LOCK_DEPTH-1:0] lk_vld;
    logic [9:0]            lk_addr [LOCK_DEPTH];
    logic [LOCK_DEPTH-1:0] rd_hit_vec;
    logic [LOCK_DEPTH-1:0] upd_hit_vec;
    logic [LOCK_DEPTH-1:0] upd_clr;
    logic [LOCK_DEPTH-1:0] keep_vld;
    logic [LOCK_DEPTH-1:0] alloc_vec;
    logic [LOCK_DEPTH-1:0] lk_vld_nxt;
    logic                  upd_found;
    logic                  alloc_found;

    logic rd_locked;
    logic upd_hit;
    logic tbl_full;
    logic byp_ok;
    logic upd_acc;
    logic rd_acc;
    logic norm_acc;
    logic lock_alloc;

    // Result slots: q_* holds results due 1 and 2 cycles after the current one.
    logic [1:0]      q_vld;
    logic [1:0]      q_byp;
    logic [1:0][7:0] q_data;
    logic [2:0]      ins_vld;
    logic [2:0]      ins_byp;
    logic [2:0][7:0] ins_data;

    always_comb begin
        rd_hit_vec  = '0;
        upd_hit_vec = '0;
        for (int unsigned i = 0; i < LOCK_DEPTH; i++) begin
            rd_hit_vec[i]  = lk_vld[i] && (lk_addr[i] == rd_addr);
            upd_hit_vec[i] = lk_vld[i] && (lk_addr[i] == upd_addr);
        end
    end

    assign rd_locked = |rd_hit_vec;
    assign upd_hit   = |upd_hit_vec;
    assign tbl_full  = &lk_vld;

`ifdef QDEC_CTX_BYPASS_EN
    assign byp_ok = upd_vld && rd_locked && (upd_addr == rd_addr);
`else
    assign byp_ok = 1'b0;
`endif

    assign upd_rdy = !init_en;
    assign rd_rdy  = !init_en &&
                     (byp_ok || (!rd_locked && !upd_vld && (!tbl_full || !rd_lock)));

    assign upd_acc    = upd_vld && upd_rdy;
    assign rd_acc     = rd_vld && rd_rdy;
    assign norm_acc   = rd_acc && !byp_ok;
    assign lock_alloc = rd_acc && rd_lock;

    always_comb begin
        upd_clr   = '0;
        upd_found = 1'b0;
        for (int unsigned i = 0; i < LOCK_DEPTH; i++) begin
            if (upd_hit_vec[i] && !upd_found) begin
                upd_clr[i] = 1'b1;
                upd_found  = 1'b1;
            end
        end
    end

    // The freed entry is visible to the allocator, so a same-cycle unlock/relock works when full.
    always_comb begin
        keep_vld    = lk_vld & ~(upd_acc ? upd_clr : '0);
        alloc_vec   = '0;
        alloc_found = 1'b0;
        for (int unsigned i = 0; i < LOCK_DEPTH; i++) begin
            if (lock_alloc && !keep_vld[i] && !alloc_found) begin
                alloc_vec[i] = 1'b1;
                alloc_found  = 1'b1;
            end
        end
        lk_vld_nxt = keep_vld | alloc_vec;
    end

    always_ff @(posedge clk) begin
        if (rst || init_en) begin
            lk_vld <= '0;
        end else begin
            lk_vld <= lk_vld_nxt;
            for (int unsigned i = 0; i < LOCK_DEPTH; i++) begin
                if (alloc_vec[i]) begin
                    lk_addr[i] <= rd_addr;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || init_en) begin
            err <= 1'b0;
        end else if (upd_acc && !upd_hit) begin
            err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
            mem_re    <= 1'b0;
        end else if (init_en) begin
            mem_addr  <= init_addr;
            mem_wdata <= init_wdata;
            mem_we    <= init_we;
            mem_re    <= 1'b0;
        end else if (upd_acc) begin
            mem_addr  <= upd_addr;
            mem_wdata <= upd_data;
            mem_we    <= 1'b1;
            mem_re    <= 1'b0;
        end else if (norm_acc) begin
            mem_addr  <= rd_addr;
            mem_we    <= 1'b0;
            mem_re    <= 1'b1;
        end else begin
            mem_we    <= 1'b0;
            mem_re    <= 1'b0;
        end
    end

    // A bypass result queues behind every read still in flight, keeping results in order.
    always_comb begin
        ins_vld     = {1'b0, q_vld};
        ins_byp     = {1'b0, q_byp};
        ins_data[0] = q_data[0];
        ins_data[1] = q_data[1];
        ins_data[2] = '0;
        if (norm_acc) begin
            ins_vld[2] = 1'b1;
            ins_byp[2] = 1'b0;
        end
`ifdef QDEC_CTX_BYPASS_EN
        if (rd_acc && byp_ok) begin
            if (q_vld[1]) begin
                ins_vld[2]  = 1'b1;
                ins_byp[2]  = 1'b1;
                ins_data[2] = upd_data;
            end else if (q_vld[0]) begin
                ins_vld[1]  = 1'b1;
                ins_byp[1]  = 1'b1;
                ins_data[1] = upd_data;
            end else begin
                ins_vld[0]  = 1'b1;
                ins_byp[0]  = 1'b1;
                ins_data[0] = upd_data;
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_vld       <= '0;
            q_byp       <= '0;
            q_data      <= '0;
            rd_data     <= '0;
            rd_data_vld <= 1'b0;
        end else begin
            q_vld       <= ins_vld[2:1];
            q_byp       <= ins_byp[2:1];
            q_data[0]   <= ins_data[1];
            q_data[1]   <= ins_data[2];
            rd_data_vld <= ins_vld[0];
            if (ins_vld[0]) begin
                rd_data <= ins_byp[0] ? ins_data[0] : mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_qdec_ctx_arb.sv
// Directed bench for qdec_ctx_arb: vector table for accept logic plus multi-cycle sequences.
`timescale 1ns/1ps
module tb_qdec_ctx_arb;

    logic       clk = 1'b0;
    logic       rst;
    logic       init_en;
    logic [9:0] init_addr;
    logic [7:0] init_wdata;
    logic       init_we;
    logic [9:0] rd_addr;
    logic       rd_lock;
    logic       rd_vld;
    logic       rd_rdy;
    logic [7:0] rd_data;
    logic       rd_data_vld;
    logic [9:0] upd_addr;
    logic [7:0] upd_data;
    logic       upd_vld;
    logic       upd_rdy;
    logic [9:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       mem_we;
    logic       mem_re;
    logic [7:0] mem_rdata;
    logic       err;

    int errors = 0;
    int checks = 0;

`ifdef QDEC_CTX_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    typedef struct {
        logic       init_en;
        logic [9:0] rd_addr;
        logic       rd_lock;
        logic       upd_vld;
        logic [9:0] upd_addr;
        logic       exp_rd_rdy;
        logic       exp_upd_rdy;
    } vec_t;

    vec_t vt [10];

    always #5 clk = ~clk;

    qdec_ctx_arb #(.LOCK_DEPTH(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .init_en     (init_en),
        .init_addr   (init_addr),
        .init_wdata  (init_wdata),
        .init_we     (init_we),
        .rd_addr     (rd_addr),
        .rd_lock     (rd_lock),
        .rd_vld      (rd_vld),
        .rd_rdy      (rd_rdy),
        .rd_data     (rd_data),
        .rd_data_vld (rd_data_vld),
        .upd_addr    (upd_addr),
        .upd_data    (upd_data),
        .upd_vld     (upd_vld),
        .upd_rdy     (upd_rdy),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_we      (mem_we),
        .mem_re      (mem_re),
        .mem_rdata   (mem_rdata),
        .err         (err)
    );

    // Single-port context RAM with one-cycle registered read
    logic [7:0] ram [1024];
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= ram[mem_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic probe(input string name, input logic [9:0] a, input logic l, input logic exp);
        @(negedge clk);
        rd_addr = a;
        rd_lock = l;
        #1 chk(name, rd_rdy, exp);
    endtask

    initial begin
        vt[0] = '{1'b1, 10'h155, 1'b0, 1'b0, 10'h000, 1'b0, 1'b0};
        vt[1] = '{1'b0, 10'h155, 1'b0, 1'b0, 10'h000, 1'b1, 1'b1};
        vt[2] = '{1'b0, 10'h155, 1'b1, 1'b0, 10'h000, 1'b0, 1'b1};
        vt[3] = '{1'b0, 10'h010, 1'b0, 1'b0, 10'h000, 1'b0, 1'b1};
        vt[4] = '{1'b0, 10'h010, 1'b1, 1'b0, 10'h000, 1'b0, 1'b1};
        vt[5] = '{1'b0, 10'h155, 1'b0, 1'b1, 10'h155, 1'b0, 1'b1};
        vt[6] = '{1'b0, 10'h010, 1'b1, 1'b1, 10'h010, BYP,  1'b1};
        vt[7] = '{1'b0, 10'h010, 1'b0, 1'b1, 10'h020, 1'b0, 1'b1};
        vt[8] = '{1'b0, 10'h020, 1'b0, 1'b1, 10'h020, BYP,  1'b1};
        vt[9] = '{1'b1, 10'h010, 1'b1, 1'b1, 10'h010, 1'b0, 1'b0};

        rst = 1'b1; init_en = 1'b0; init_addr = '0; init_wdata = '0; init_we = 1'b0;
        rd_addr = '0; rd_lock = 1'b0; rd_vld = 1'b0;
        upd_addr = '0; upd_data = '0; upd_vld = 1'b0;

        repeat (3) @(negedge clk);
        #1;
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_re", mem_re, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_rd_data_vld", rd_data_vld, 0);
        chk("rst_err", err, 0);
        @(negedge clk);
        rst = 1'b0;

        // Init every word with its low address byte
        @(negedge clk);
        init_en = 1'b1;
        for (int i = 0; i < 1024; i++) begin
            init_we = 1'b1;
            init_addr = i[9:0];
            init_wdata = i[7:0];
            #1;
            if (i == 0) begin
                chk("init_rd_rdy", rd_rdy, 0);
                chk("init_upd_rdy", upd_rdy, 0);
            end
            if (i == 2) begin
                chk("init_mem_we", mem_we, 1);
                chk("init_mem_addr", mem_addr, 1);
                chk("init_mem_wdata", mem_wdata, 1);
            end
            @(negedge clk);
        end
        init_en = 1'b0;
        init_we = 1'b0;
        @(negedge clk);

        // Plain read, latency 3
        @(negedge clk);
        rd_vld = 1'b1; rd_addr = 10'h155; rd_lock = 1'b0;
        #1 chk("a_rd_rdy", rd_rdy, 1);
        @(negedge clk);
        rd_vld = 1'b0;
        #1;
        chk("a_mem_re", mem_re, 1);
        chk("a_mem_addr", mem_addr, 10'h155);
        chk("a_vld_t1", rd_data_vld, 0);
        @(negedge clk);
        #1 chk("a_vld_t2", rd_data_vld, 0);
        @(negedge clk);
        #1;
        chk("a_vld_t3", rd_data_vld, 1);
        chk("a_data_t3", rd_data, 8'h55);
        @(negedge clk);
        #1 chk("a_vld_t4", rd_data_vld, 0);

        // Lock 0x010 and 0x020 back to back
        @(negedge clk);
        rd_vld = 1'b1; rd_lock = 1'b1; rd_addr = 10'h010;
        #1 chk("b_lock010_rdy", rd_rdy, 1);
        @(negedge clk);
        rd_addr = 10'h020;
        #1 chk("b_lock020_rdy", rd_rdy, 1);
        @(negedge clk);
        rd_vld = 1'b0; rd_lock = 1'b0;
        @(negedge clk);
        #1;
        chk("b_vld0", rd_data_vld, 1);
        chk("b_data0", rd_data, 8'h10);
        @(negedge clk);
        #1;
        chk("b_vld1", rd_data_vld, 1);
        chk("b_data1", rd_data, 8'h20);
        @(negedge clk);
        #1 chk("b_vld2", rd_data_vld, 0);

        // Accept logic against a full table {0x010, 0x020}
        for (int v = 0; v < 10; v++) begin
            @(negedge clk);
            init_en = vt[v].init_en;
            rd_addr = vt[v].rd_addr;
            rd_lock = vt[v].rd_lock;
            upd_vld = vt[v].upd_vld;
            upd_addr = vt[v].upd_addr;
            #1;
            chk($sformatf("vec%0d_rd_rdy", v), rd_rdy, vt[v].exp_rd_rdy);
            chk($sformatf("vec%0d_upd_rdy", v), upd_rdy, vt[v].exp_upd_rdy);
            upd_vld = 1'b0;
            init_en = 1'b0;
            rd_lock = 1'b0;
        end

        // Re-read of a locked context waits for its update
        @(negedge clk);
        rd_vld = 1'b1; rd_lock = 1'b1; rd_addr = 10'h010;
        #1 chk("c_stall1", rd_rdy, 0);
        @(negedge clk);
        #1 chk("c_stall2", rd_rdy, 0);
        @(negedge clk);
        upd_vld = 1'b1; upd_addr = 10'h010; upd_data = 8'hA3;
        #1 chk("c_upd_rdy", upd_rdy, 1);
`ifdef QDEC_CTX_BYPASS_EN
        chk("c_byp_rdy", rd_rdy, 1);
        @(negedge clk);
        upd_vld = 1'b0; rd_vld = 1'b0; rd_lock = 1'b0;
        #1;
        chk("c_byp_vld", rd_data_vld, 1);
        chk("c_byp_data", rd_data, 8'hA3);
        chk("c_mem_we", mem_we, 1);
        chk("c_mem_addr", mem_addr, 10'h010);
        chk("c_mem_wdata", mem_wdata, 8'hA3);
        chk("c_no_mem_re", mem_re, 0);
        @(negedge clk);
        #1 chk("c_byp_vld_end", rd_data_vld, 0);
`else
        chk("c_upd_cycle_rdy", rd_rdy, 0);
        @(negedge clk);
        upd_vld = 1'b0;
        #1;
        chk("c_rdy_after_upd", rd_rdy, 1);
        chk("c_mem_we", mem_we, 1);
        chk("c_mem_addr", mem_addr, 10'h010);
        chk("c_mem_wdata", mem_wdata, 8'hA3);
        @(negedge clk);
        rd_vld = 1'b0; rd_lock = 1'b0;
        #1;
        chk("c_mem_re", mem_re, 1);
        chk("c_mem_re_addr", mem_addr, 10'h010);
        @(negedge clk);
        #1 chk("c_vld_early", rd_data_vld, 0);
        @(negedge clk);
        #1;
        chk("c_vld", rd_data_vld, 1);
        chk("c_data", rd_data, 8'hA3);
`endif
        @(negedge clk);
        upd_vld = 1'b1; upd_addr = 10'h010; upd_data = 8'hA3;
        @(negedge clk);
        upd_addr = 10'h020; upd_data = 8'h20;
        @(negedge clk);
        upd_vld = 1'b0;
        #1 chk("c_err_clean", err, 0);

        // Full table blocks a third lock until one entry is freed
        @(negedge clk);
        rd_vld = 1'b1; rd_lock = 1'b1; rd_addr = 10'h001;
        #1 chk("d_lock001", rd_rdy, 1);
        @(negedge clk);
        rd_addr = 10'h002;
        #1 chk("d_lock002", rd_rdy, 1);
        @(negedge clk);
        rd_addr = 10'h003;
        #1 chk("d_full_stall", rd_rdy, 0);
        @(negedge clk);
        upd_vld = 1'b1; upd_addr = 10'h001; upd_data = 8'h01;
        #1 chk("d_upd_cycle", rd_rdy, 0);
        @(negedge clk);
        upd_vld = 1'b0;
        #1 chk("d_accept", rd_rdy, 1);
        @(negedge clk);
        rd_vld = 1'b0;
        rd_lock = 1'b0;
        probe("d_tbl_002", 10'h002, 1'b0, 1'b0);
        probe("d_tbl_003", 10'h003, 1'b0, 1'b0);
        probe("d_tbl_001", 10'h001, 1'b0, 1'b1);
        probe("d_tbl_full", 10'h004, 1'b1, 1'b0);
        rd_lock = 1'b0;
        @(negedge clk);
        upd_vld = 1'b1; upd_addr = 10'h002; upd_data = 8'h02;
        @(negedge clk);
        upd_addr = 10'h003; upd_data = 8'h03;
        @(negedge clk);
        upd_vld = 1'b0;
        #1 chk("d_err_clean", err, 0);

        // upd and rd in the same cycle: write goes first
        @(negedge clk);
        rd_vld = 1'b1; rd_lock = 1'b1; rd_addr = 10'h030;
        @(negedge clk);
        rd_vld = 1'b0; rd_lock = 1'b0;
        repeat (4) @(negedge clk);
        upd_vld = 1'b1; upd_addr = 10'h030; upd_data = 8'h5A;
        rd_vld = 1'b1; rd_addr = 10'h020;
        #1 chk("e_rd_blocked", rd_rdy, 0);
        @(negedge clk);
        upd_vld = 1'b0;
        #1;
        chk("e_mem_we", mem_we, 1);
        chk("e_mem_re_low", mem_re, 0);
        chk("e_mem_addr_w", mem_addr, 10'h030);
        chk("e_rd_rdy", rd_rdy, 1);
        @(negedge clk);
        rd_vld = 1'b0;
        #1;
        chk("e_mem_re", mem_re, 1);
        chk("e_mem_we_low", mem_we, 0);
        chk("e_mem_addr_r", mem_addr, 10'h020);
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("e_vld", rd_data_vld, 1);
        chk("e_data", rd_data, 8'h20);
        chk("e_err", err, 0);

        // Unmatched update: write happens, err is sticky until init_en
        @(negedge clk);
        upd_vld = 1'b1; upd_addr = 10'h3FF; upd_data = 8'hC3;
        @(negedge clk);
        upd_vld = 1'b0;
        #1;
        chk("f_mem_we", mem_we, 1);
        chk("f_mem_addr", mem_addr, 10'h3FF);
        chk("f_mem_wdata", mem_wdata, 8'hC3);
        chk("f_err_set", err, 1);
        repeat (3) @(negedge clk);
        #1 chk("f_err_sticky", err, 1);
        @(negedge clk);
        init_en = 1'b1;
        @(negedge clk);
        init_en = 1'b0;
        #1 chk("f_err_cleared", err, 0);

        // Reset one cycle after a locked read is accepted
        @(negedge clk);
        upd_vld = 1'b1; upd_addr = 10'h3FE; upd_data = 8'h11;
        @(negedge clk);
        upd_vld = 1'b0;
        rd_vld = 1'b1; rd_lock = 1'b1; rd_addr = 10'h040;
        #1 chk("g_rd_rdy", rd_rdy, 1);
        @(negedge clk);
        rd_vld = 1'b0; rd_lock = 1'b0; rst = 1'b1;
        #1 chk("g_mem_re", mem_re, 1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("g_mem_addr", mem_addr, 0);
        chk("g_mem_wdata", mem_wdata, 0);
        chk("g_mem_we", mem_we, 0);
        chk("g_mem_re0", mem_re, 0);
        chk("g_rd_data", rd_data, 0);
        chk("g_vld_t2", rd_data_vld, 0);
        chk("g_err", err, 0);
        @(negedge clk);
        #1 chk("g_vld_t3", rd_data_vld, 0);
        @(negedge clk);
        #1 chk("g_vld_t4", rd_data_vld, 0);
        @(negedge clk);
        rd_vld = 1'b1; rd_lock = 1'b1; rd_addr = 10'h040;
        #1 chk("g_relock", rd_rdy, 1);
        @(negedge clk);
        rd_vld = 1'b0; rd_lock = 1'b0;
        repeat (4) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
